// File: rtl/token_thin_arbiter.sv
// token_thin_arbiter: per-requester token thinning (keep 1 of every K '1'
// tokens), a one-deep pending slot per requester, and round-robin grant
// of pending tokens onto a single valid/ready output.
module token_thin_arbiter #(
  parameter int N  = 4,
  parameter int KW = 4,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  a,
  input  logic          cfg_we,
  input  logic [SW-1:0] cfg_idx,
  input  logic [KW-1:0] cfg_ratio,
  output logic          out_valid,
  output logic [SW-1:0] out_src,
  input  logic          out_ready,
  output logic [N-1:0]  ovf
);

  logic [KW-1:0] cnt   [N];
  logic [KW-1:0] ratio [N];
  logic [N-1:0]  pending;
  logic [SW-1:0] last;

  logic [N-1:0]  cfg_hit;
  logic [N-1:0]  tok;
  logic [N-1:0]  kept;
  logic [N-1:0]  upper;
  logic [N-1:0]  masked;
  logic [N-1:0]  sel_vec;
  logic [N-1:0]  gnt_oh;
  logic [N-1:0]  pending_nxt;
  logic [N-1:0]  ovf_nxt;
  logic          gnt_any;
  logic [SW-1:0] gnt_idx;
  logic          load;

  // The output register may take a new token when empty or being consumed.
  assign load = !out_valid || out_ready;

  // Decode the config write target; out-of-range indices match nothing.
  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < N; i++) begin
      cfg_hit[i] = cfg_we && (cfg_idx == SW'(i));
    end
  end

  // Thinning: a token written over by config is ignored; K=0 drops all.
  always_comb begin
    tok  = '0;
    kept = '0;
    for (int i = 0; i < N; i++) begin
      tok[i]  = a[i] && !cfg_hit[i];
      kept[i] = tok[i] && (ratio[i] != '0) && (cnt[i] == ratio[i] - KW'(1));
    end
  end

  // Round-robin pick: lowest pending index above last, else lowest overall.
  always_comb begin
    upper   = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = SW'(i) > last;
    end
    masked  = pending & upper;
    sel_vec = (|masked) ? masked : pending;
    gnt_any = |pending;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_vec[i]) gnt_idx = SW'(i);
    end
    gnt_oh = '0;
    for (int i = 0; i < N; i++) begin
      gnt_oh[i] = load && gnt_any && (gnt_idx == SW'(i));
    end
  end

  // Pending slot update; a granted slot can be refilled in the same cycle.
  always_comb begin
    pending_nxt = pending & ~gnt_oh;
    ovf_nxt     = ovf;
    for (int i = 0; i < N; i++) begin
      if (kept[i]) begin
        if (pending_nxt[i]) ovf_nxt[i] = 1'b1;
        pending_nxt[i] = 1'b1;
      end
    end
  end

  // Per-requester ratio and thinning counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt[i]   <= '0;
        ratio[i] <= KW'(2);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cfg_hit[i]) begin
          ratio[i] <= cfg_ratio;
          cnt[i]   <= '0;
        end else if (tok[i] && (ratio[i] != '0)) begin
          cnt[i] <= kept[i] ? '0 : cnt[i] + KW'(1);
        end
      end
    end
  end

  // Pending slots, sticky overflow, output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      last      <= SW'(N - 1);
    end else begin
      pending <= pending_nxt;
      ovf     <= ovf_nxt;
      if (load) begin
        out_valid <= gnt_any;
        if (gnt_any) begin
          out_src <= gnt_idx;
          last    <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_token_thin_arbiter.sv
// Testbench for token_thin_arbiter: directed scenarios plus a random phase,
// every cycle compared against a behavioural model of the thinning and
// round-robin rules.
module tb_token_thin_arbiter;

  localparam int N  = 4;
  localparam int KW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  a = '0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_idx = '0;
  logic [KW-1:0] cfg_ratio = '0;
  logic          out_valid;
  logic [SW-1:0] out_src;
  logic          out_ready = 1'b0;
  logic [N-1:0]  ovf;

  int checks = 0;
  int failures = 0;

  // model state
  int       m_cnt   [N];
  int       m_ratio [N];
  bit [N-1:0] m_pend;
  bit [N-1:0] m_ovf;
  bit       m_valid;
  int       m_src;
  int       m_last;

  int src_log[$];

  token_thin_arbiter #(.N(N), .KW(KW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_ratio(cfg_ratio), .out_valid(out_valid), .out_src(out_src),
    .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i]   = 0;
      m_ratio[i] = 2;
    end
    m_pend  = '0;
    m_ovf   = '0;
    m_valid = 1'b0;
    m_src   = 0;
    m_last  = N - 1;
  endtask

  // One clock of the rules, evaluated from the inputs currently driven.
  task automatic model_step();
    bit ld;
    bit hit;
    int g;
    bit [N-1:0] keep;
    ld = !m_valid || out_ready;
    g = -1;
    if (ld) begin
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
      end
    end
    keep = '0;
    for (int i = 0; i < N; i++) begin
      hit = cfg_we && (int'(cfg_idx) == i);
      if (a[i] && !hit && m_ratio[i] != 0) begin
        if (m_cnt[i] == m_ratio[i] - 1) begin
          keep[i] = 1'b1;
          m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (hit) begin
        m_ratio[i] = int'(cfg_ratio);
        m_cnt[i]   = 0;
      end
    end
    if (g >= 0) m_pend[g] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (keep[i]) begin
        if (m_pend[i]) m_ovf[i] = 1'b1;
        else m_pend[i] = 1'b1;
      end
    end
    if (ld) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_src  = g;
        m_last = g;
      end
    end
  endtask

  task automatic compare_all();
    chk_val("out_valid", 32'(out_valid), 32'(m_valid));
    chk_val("out_src", 32'(out_src), 32'(m_src));
    chk_val("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    if (out_valid) src_log.push_back(int'(out_src));
  endtask

  task automatic idle(input int n);
    a = '0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a = '0;
    cfg_we = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    src_log.delete();
  endtask

  task automatic cfg_write(input int idx, input int r);
    cfg_we = 1'b1;
    cfg_idx = SW'(idx);
    cfg_ratio = KW'(r);
    cycle();
    cfg_we = 1'b0;
  endtask

  initial begin
    // 1: default ratio 2, four tokens on requester 0
    out_ready = 1'b1;
    do_reset();
    chk_val("rst_valid", 32'(out_valid), 32'd0);
    chk_val("rst_ovf", 32'(ovf), 32'd0);
    a = 4'b0001;
    for (int k = 0; k < 4; k++) cycle();
    idle(3);
    chk_val("t1_grants", 32'(src_log.size()), 32'd2);
    chk_val("t1_ovf", 32'(ovf), 32'd0);

    // 2: ratio 1 on all, one burst -> 0,1,2,3 back to back
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(i, 1);
    src_log.delete();
    a = 4'b1111;
    cycle();
    idle(6);
    chk_val("t2_len", 32'(src_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < src_log.size(); k++) chk_val("t2_src", 32'(src_log[k]), 32'(k));

    // 3: stalled output holds src 2, then refill, then overflow
    do_reset();
    cfg_write(2, 1);
    out_ready = 1'b0;
    a = 4'b0100;
    cycle();
    idle(1);
    a = 4'b0100;
    cycle();
    cycle();
    idle(2);
    chk_val("t3_valid", 32'(out_valid), 32'd1);
    chk_val("t3_src", 32'(out_src), 32'd2);
    chk_val("t3_ovf", 32'(ovf), 32'h4);
    out_ready = 1'b1;
    idle(3);

    // 4: ratio 0 drops everything; ratio 3 written with a coincident token
    do_reset();
    cfg_write(1, 0);
    src_log.delete();
    a = 4'b0010;
    for (int k = 0; k < 10; k++) cycle();
    idle(2);
    chk_val("t4_none", 32'(src_log.size()), 32'd0);
    a = 4'b0010;
    cfg_write(1, 3);
    a = 4'b0010;
    cycle();
    cycle();
    idle(2);
    chk_val("t4_two", 32'(src_log.size()), 32'd0);
    a = 4'b0010;
    cycle();
    idle(2);
    chk_val("t4_three", 32'(src_log.size()), 32'd1);

    // 5: two streams kept every cycle -> alternating grants
    do_reset();
    cfg_write(0, 1);
    cfg_write(3, 1);
    src_log.delete();
    a = 4'b1001;
    for (int k = 0; k < 6; k++) cycle();
    for (int k = 0; k < 4 && k < src_log.size(); k++)
      chk_val("t5_alt", 32'(src_log[k]), (k % 2 == 0) ? 32'd0 : 32'd3);
    idle(4);

    // 6: reset mid-stream with a token presented and slots pending
    do_reset();
    for (int i = 0; i < N; i++) cfg_write(i, 1);
    out_ready = 1'b0;
    a = 4'b1111;
    cycle();
    cycle();
    chk_val("t6_pre_valid", 32'(out_valid), 32'd1);
    do_reset();
    chk_val("t6_async_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    a = 4'b0001;
    cycle();
    cycle();
    idle(3);
    chk_val("t6_grants", 32'(src_log.size()), 32'd1);

    // random phase
    do_reset();
    for (int k = 0; k < 500; k++) begin
      a = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 9) == 0);
      cfg_idx = SW'($urandom);
      cfg_ratio = KW'($urandom_range(0, 4));
      cycle();
      if (k == 250) do_reset();
    end
    cfg_we = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
